// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC core: one micro-rotation per clock on a shared X/Y/Z datapath,
// rotation or vectoring mode, start/busy/done handshake, arctan ROM outside the block.
module cordic_iter_engine #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic [IDX_W-1:0] atan_idx,
    input  logic [WIDTH-1:0] atan_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]        i_q, i_d;
    logic                    mode_q, mode_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0]        x_out_q, x_out_d;
    logic [WIDTH-1:0]        y_out_q, y_out_d;
    logic [WIDTH-1:0]        z_out_q, z_out_d;

    // Micro-rotation datapath for the current index.
    logic signed [WIDTH-1:0] x_sh, y_sh;
    logic signed [WIDTH-1:0] x_nxt, y_nxt, z_nxt;
    logic                    dir_pos;
    logic                    last_iter;

    assign x_sh = x_q >>> i_q;
    assign y_sh = y_q >>> i_q;

    // Rotation steers Z toward zero; vectoring steers Y toward zero.
    assign dir_pos = mode_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];

    assign x_nxt = dir_pos ? (x_q - y_sh) : (x_q + y_sh);
    assign y_nxt = dir_pos ? (y_q + x_sh) : (y_q - x_sh);
    assign z_nxt = dir_pos ? (z_q - $signed(atan_value)) : (z_q + $signed(atan_value));

    assign last_iter = (i_q == IDX_W'(ITER - 1));

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    x_d     = x_in;
                    y_d     = y_in;
                    z_d     = z_in;
                    i_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                x_d = x_nxt;
                y_d = y_nxt;
                z_d = z_nxt;
                if (last_iter) begin
                    // Index returns to zero instead of incrementing past ITER-1.
                    i_d     = '0;
                    x_out_d = x_nxt;
                    y_out_d = y_nxt;
                    z_out_d = z_nxt;
                    state_d = S_DONE;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign atan_idx = i_q;
    assign x_out    = x_out_q;
    assign y_out    = y_out_q;
    assign z_out    = z_out_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: directed vector table with hand-computed
// results, plus start-storm, operand-isolation and mid-run reset sequences.
module tb_cordic_iter_engine;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;
    localparam int IDX_W = 4;
    localparam int TOL   = 16;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] x_in, y_in, z_in;
    logic [IDX_W-1:0] atan_idx;
    logic [WIDTH-1:0] atan_value;
    logic             busy, done;
    logic [WIDTH-1:0] x_out, y_out, z_out;

    int checks = 0;
    int errors = 0;

    cordic_iter_engine #(
        .WIDTH(WIDTH),
        .ITER (ITER),
        .IDX_W(IDX_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .atan_idx  (atan_idx),
        .atan_value(atan_value),
        .busy      (busy),
        .done      (done),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Golden arctan ROM: round(atan(2^-i) * 2^15 / pi).
    function automatic logic [WIDTH-1:0] atan_rom(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:  atan_rom = 16'd8192;
            4'd1:  atan_rom = 16'd4836;
            4'd2:  atan_rom = 16'd2555;
            4'd3:  atan_rom = 16'd1297;
            4'd4:  atan_rom = 16'd651;
            4'd5:  atan_rom = 16'd326;
            4'd6:  atan_rom = 16'd163;
            4'd7:  atan_rom = 16'd81;
            4'd8:  atan_rom = 16'd41;
            4'd9:  atan_rom = 16'd20;
            4'd10: atan_rom = 16'd10;
            4'd11: atan_rom = 16'd5;
            4'd12: atan_rom = 16'd3;
            4'd13: atan_rom = 16'd1;
            4'd14: atan_rom = 16'd1;
            default: atan_rom = 16'd0;
        endcase
    endfunction

    always_comb atan_value = atan_rom(atan_idx);

    typedef struct {
        logic             mode;
        logic [WIDTH-1:0] x, y, z;
        logic [WIDTH-1:0] ex, ey, ez;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp, input int tol);
        logic [WIDTH-1:0] diff;
        int d;
        checks++;
        diff = act - exp;
        d = int'($signed(diff));
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Launch one operation, scramble the inputs after the accepting edge, and
    // count edges until done (bounded).
    task automatic run_op(input vec_t v, output logic busy_after, output int lat);
        @(negedge clock);
        start = 1'b1;
        mode  = v.mode;
        x_in  = v.x;
        y_in  = v.y;
        z_in  = v.z;
        @(posedge clock);
        #1;
        busy_after = busy;
        start = 1'b0;
        mode  = ~v.mode;
        x_in  = 16'($urandom);
        y_in  = 16'($urandom);
        z_in  = 16'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        int   lat;
        int   n_done, last_pos, first_pos;
        logic prev_done;

        //            mode  x        y        z        ex       ey       ez
        vecs[0] = '{1'b0, 16'h26DE, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 16'h26DE, 16'h0000, 16'h2000, 16'h2D41, 16'h2D41, 16'h0000};
        vecs[2] = '{1'b0, 16'h26DE, 16'h0000, 16'hE000, 16'h2D41, 16'hD2BF, 16'h0000};
        vecs[3] = '{1'b1, 16'h2000, 16'h2000, 16'h0000, 16'h4A87, 16'h0000, 16'h2000};
        vecs[4] = '{1'b0, 16'h26DE, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000};
        vecs[5] = '{1'b0, 16'h0000, 16'h26DE, 16'h2000, 16'hD2BF, 16'h2D41, 16'h0000};
        vecs[6] = '{1'b1, 16'h4000, 16'h0000, 16'h0000, 16'h6965, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 16'h2000, 16'hE000, 16'h0000, 16'h4A87, 16'h0000, 16'hE000};

        reset_n = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        x_in    = '0;
        y_in    = '0;
        z_in    = '0;
        #13;
        check("reset_busy",  16'(busy), 16'd0, 0);
        check("reset_done",  16'(done), 16'd0, 0);
        check("reset_idx",   16'(atan_idx), 16'd0, 0);
        check("reset_x_out", x_out, 16'd0, 0);
        check("reset_y_out", y_out, 16'd0, 0);
        check("reset_z_out", z_out, 16'd0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], b, lat);
            check($sformatf("v%0d_busy", i), 16'(b), 16'd1, 0);
            check($sformatf("v%0d_latency", i), 16'(lat), 16'(ITER), 0);
            check($sformatf("v%0d_x", i), x_out, vecs[i].ex, TOL);
            check($sformatf("v%0d_y", i), y_out, vecs[i].ey, TOL);
            check($sformatf("v%0d_z", i), z_out, vecs[i].ez, TOL);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_done_width", i), 16'(done), 16'd0, 0);
            check($sformatf("v%0d_idle", i), 16'(busy), 16'd0, 0);
        end

        // Results hold while idle.
        repeat (4) @(posedge clock);
        #1;
        check("hold_x", x_out, vecs[7].ex, TOL);
        check("hold_z", z_out, vecs[7].ez, TOL);

        // start held high continuously: accepts at k=0,18,36; done at k=16,34,52.
        @(negedge clock);
        start = 1'b1;
        mode  = vecs[0].mode;
        x_in  = vecs[0].x;
        y_in  = vecs[0].y;
        z_in  = vecs[0].z;
        n_done    = 0;
        last_pos  = -1;
        first_pos = -1;
        prev_done = 1'b0;
        for (int k = 0; k < 54; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                if (prev_done) check("storm_done_width", 16'd2, 16'd1, 0);
                if (first_pos < 0) first_pos = k;
                else check("storm_gap", 16'(k - last_pos), 16'd18, 0);
                check("storm_x", x_out, vecs[0].ex, TOL);
                last_pos = k;
                n_done++;
            end
            prev_done = done;
        end
        start = 1'b0;
        check("storm_first_done", 16'(first_pos), 16'd16, 0);
        check("storm_done_count", 16'(n_done), 16'd3, 0);
        repeat (3) @(posedge clock);

        // Reset while i=7: everything clears at once, then a fresh op works.
        @(negedge clock);
        start = 1'b1;
        mode  = vecs[2].mode;
        x_in  = vecs[2].x;
        y_in  = vecs[2].y;
        z_in  = vecs[2].z;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        check("abort_idx_before", 16'(atan_idx), 16'd7, 0);
        reset_n = 1'b0;
        #1;
        check("abort_busy",  16'(busy), 16'd0, 0);
        check("abort_done",  16'(done), 16'd0, 0);
        check("abort_idx",   16'(atan_idx), 16'd0, 0);
        check("abort_x_out", x_out, 16'd0, 0);
        check("abort_y_out", y_out, 16'd0, 0);
        check("abort_z_out", z_out, 16'd0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("abort_no_done", 16'(done), 16'd0, 0);
        run_op(vecs[1], b, lat);
        check("post_abort_latency", 16'(lat), 16'(ITER), 0);
        check("post_abort_x", x_out, vecs[1].ex, TOL);
        check("post_abort_y", y_out, vecs[1].ey, TOL);
        check("post_abort_z", z_out, vecs[1].ez, TOL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
